// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcode encodings and shared types for the sequential ALU
// Purpose: single home for the instruction-set opcode values and the FSM /
//          iterative-unit enums used by alu_seq and alu_iter_unit.
// Ports:   none (package).
package alu_seq_pkg;

  // Opcode encodings. ADD..NOT keep their original values; the later codes
  // extend the table.
  localparam logic [4:0] OP_ADD = 5'h00;
  localparam logic [4:0] OP_ADC = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_INC = 5'h03;
  localparam logic [4:0] OP_DEC = 5'h04;
  localparam logic [4:0] OP_AND = 5'h05;
  localparam logic [4:0] OP_OR  = 5'h06;
  localparam logic [4:0] OP_XOR = 5'h07;
  localparam logic [4:0] OP_NOT = 5'h08;
  localparam logic [4:0] OP_SBB = 5'h09;
  localparam logic [4:0] OP_SHL = 5'h0A;
  localparam logic [4:0] OP_SHR = 5'h0B;
  localparam logic [4:0] OP_SAR = 5'h0C;
  localparam logic [4:0] OP_MUL = 5'h0D;
  localparam logic [4:0] OP_CMP = 5'h0E;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_MUL} state_t;

  typedef enum logic [1:0] {IT_SHL, IT_SHR, IT_SAR, IT_MUL} iter_op_t;

endpackage

// File: rtl/alu_iter_unit.sv
// rtl/alu_iter_unit.sv - one-bit-per-step shifter and shift-add multiplier
// Purpose: holds operands, step counter and step datapath for iterative ops.
// Ports:   clk, rst_n      - clock, async active-low reset
//          load, op, amt   - capture in_a/in_b and the op; amt = shift count
//          in_a, in_b      - operands (in_b is the multiplier for MUL)
//          step            - advance one bit
//          last            - the current step is the final one
//          result/carry/ovf- value the registers take on this step
module alu_iter_unit import alu_seq_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  iter_op_t         op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [SHW-1:0]   amt,
  output logic             last,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf
);
  localparam int CW = SHW + 1;

  iter_op_t         r_op;
  logic [WIDTH-1:0] r_val;  // shift value, or low product half / multiplier
  logic [WIDTH-1:0] r_hi;   // high product half
  logic [WIDTH-1:0] r_a;    // multiplicand
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_next_val;
  logic [WIDTH-1:0] w_next_hi;
  logic             w_next_c;

  // Shift-add step: add multiplicand when multiplier LSB is set, then shift
  // the {carry, hi, lo} triple right by one.
  assign w_sum = {1'b0, r_hi} + (r_val[0] ? {1'b0, r_a} : '0);

  always_comb begin
    w_next_val = r_val;
    w_next_hi  = r_hi;
    w_next_c   = 1'b0;
    case (r_op)
      IT_SHL: begin
        w_next_val = {r_val[WIDTH-2:0], 1'b0};
        w_next_c   = r_val[WIDTH-1];
      end
      IT_SHR: begin
        w_next_val = {1'b0, r_val[WIDTH-1:1]};
        w_next_c   = r_val[0];
      end
      IT_SAR: begin
        w_next_val = {r_val[WIDTH-1], r_val[WIDTH-1:1]};
        w_next_c   = r_val[0];
      end
      IT_MUL: begin
        w_next_val = {w_sum[0], r_val[WIDTH-1:1]};
        w_next_hi  = w_sum[WIDTH:1];
        w_next_c   = |w_sum[WIDTH:1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= IT_SHL;
      r_val <= '0;
      r_hi  <= '0;
      r_a   <= '0;
      r_cnt <= '0;
    end else if (load) begin
      r_op  <= op;
      r_val <= (op == IT_MUL) ? in_b : in_a;
      r_a   <= in_a;
      r_hi  <= '0;
      r_cnt <= (op == IT_MUL) ? CW'(WIDTH) : CW'(amt);
    end else if (step) begin
      r_val <= w_next_val;
      r_hi  <= w_next_hi;
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
  end

  assign last   = (r_cnt == CW'(1));
  assign result = w_next_val;
  assign carry  = w_next_c;
  assign ovf    = (r_op == IT_MUL) && w_next_c;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with registered flags and iterative ops
// Purpose: single-cycle arithmetic/logic plus multi-cycle shifts and multiply.
// Ports:   clk, rst_n          - clock, async active-low reset
//          start, opcode       - request, accepted only while not busy
//          in_a, in_b          - operands (in_b[SHW-1:0] = shift amount)
//          out                 - registered result
//          zero/sign/carry/ovf - registered flags
//          busy, done, illegal - status (done/illegal are one-cycle pulses)
module alu_seq import alu_seq_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] out,
  output logic             zero_flag,
  output logic             sign_flag,
  output logic             carry_flag,
  output logic             ovf_flag,
  output logic             busy,
  output logic             done,
  output logic             illegal
);
  localparam int M = WIDTH - 1;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_out;
  logic             r_zero, r_sign, r_carry, r_ovf, r_done, r_illegal;

  logic             w_accept, w_busy, w_step, w_load;
  logic [WIDTH-1:0] w_opb, w_res;
  logic             w_cin, w_c, w_v, w_wr_out, w_single, w_iter;
  logic [WIDTH:0]   w_add, w_sub;
  logic             w_add_v, w_sub_v;
  iter_op_t         w_iop;
  logic             w_last, w_it_c, w_it_v;
  logic [WIDTH-1:0] w_it_res;

  // INC/DEC reuse the add/sub paths with a constant 1 operand; ADC/SBB take
  // the current carry as carry-in / borrow-in.
  assign w_opb = (opcode == OP_INC || opcode == OP_DEC) ? {{(WIDTH-1){1'b0}}, 1'b1} : in_b;
  assign w_cin = (opcode == OP_ADC || opcode == OP_SBB) ? r_carry : 1'b0;
  assign w_add = {1'b0, in_a} + {1'b0, w_opb} + {{WIDTH{1'b0}}, w_cin};
  // Bit WIDTH of the difference is set exactly when in_a < w_opb + w_cin.
  assign w_sub = {1'b0, in_a} - {1'b0, w_opb} - {{WIDTH{1'b0}}, w_cin};
  assign w_add_v = (in_a[M] == w_opb[M]) && (w_add[M] != in_a[M]);
  assign w_sub_v = (in_a[M] != w_opb[M]) && (w_sub[M] != in_a[M]);

  always_comb begin
    w_res    = '0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    w_wr_out = 1'b1;
    w_single = 1'b0;
    w_iter   = 1'b0;
    w_iop    = IT_SHL;
    case (opcode)
      OP_ADD, OP_ADC, OP_INC: begin
        w_single = 1'b1; w_res = w_add[M:0]; w_c = w_add[WIDTH]; w_v = w_add_v;
      end
      OP_SUB, OP_SBB, OP_DEC, OP_CMP: begin
        w_single = 1'b1; w_res = w_sub[M:0]; w_c = w_sub[WIDTH]; w_v = w_sub_v;
        w_wr_out = (opcode != OP_CMP);
      end
      OP_AND: begin w_single = 1'b1; w_res = in_a & in_b; end
      OP_OR:  begin w_single = 1'b1; w_res = in_a | in_b; end
      OP_XOR: begin w_single = 1'b1; w_res = in_a ^ in_b; end
      OP_NOT: begin w_single = 1'b1; w_res = ~in_a; end
      OP_SHL, OP_SHR, OP_SAR: begin
        w_iop = (opcode == OP_SHL) ? IT_SHL : (opcode == OP_SHR) ? IT_SHR : IT_SAR;
        // A zero shift completes immediately with the operand unchanged.
        if (in_b[SHW-1:0] == '0) begin
          w_single = 1'b1; w_res = in_a;
        end else begin
          w_iter = 1'b1;
        end
      end
      OP_MUL: begin w_iter = 1'b1; w_iop = IT_MUL; end
      default: ;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:          if (w_accept && w_iter) w_state_nxt = (w_iop == IT_MUL) ? ST_MUL : ST_SHIFT;
      ST_SHIFT, ST_MUL: if (w_last) w_state_nxt = ST_IDLE;
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_busy   = (r_state != ST_IDLE);
    w_accept = start && (r_state == ST_IDLE);
    w_step   = w_busy;
    w_load   = w_accept && w_iter;
  end

  alu_iter_unit #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (w_load),
    .step   (w_step),
    .op     (w_iop),
    .in_a   (in_a),
    .in_b   (in_b),
    .amt    (in_b[SHW-1:0]),
    .last   (w_last),
    .result (w_it_res),
    .carry  (w_it_c),
    .ovf    (w_it_v)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out     <= '0;
      r_zero    <= 1'b0;
      r_sign    <= 1'b0;
      r_carry   <= 1'b0;
      r_ovf     <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_illegal <= w_accept && !w_single && !w_iter;
      if (w_accept && w_single) begin
        if (w_wr_out) r_out <= w_res;
        r_zero  <= (w_res == '0);
        r_sign  <= w_res[M];
        r_carry <= w_c;
        r_ovf   <= w_v;
        r_done  <= 1'b1;
      end else if (w_step && w_last) begin
        r_out   <= w_it_res;
        r_zero  <= (w_it_res == '0);
        r_sign  <= w_it_res[M];
        r_carry <= w_it_c;
        r_ovf   <= w_it_v;
        r_done  <= 1'b1;
      end
    end
  end

  assign out        = r_out;
  assign zero_flag  = r_zero;
  assign sign_flag  = r_sign;
  assign carry_flag = r_carry;
  assign ovf_flag   = r_ovf;
  assign busy       = w_busy;
  assign done       = r_done;
  assign illegal    = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq
module tb_alu_seq;
  import alu_seq_pkg::*;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [4:0]    opcode = '0;
  logic [W-1:0]  in_a = '0, in_b = '0;
  logic [W-1:0]  out;
  logic          zf, sf, cf, vf, busy, done, illegal;

  int n_vec = 0;
  int n_err = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .in_a(in_a), .in_b(in_b), .out(out),
    .zero_flag(zf), .sign_flag(sf), .carry_flag(cf), .ovf_flag(vf),
    .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [15:0] res;
    logic        wr;
    logic        c;
    logic        v;
    int          lat;
    logic        legal;
  } mres_t;

  function automatic mres_t model_op(input logic [4:0] op, input logic [15:0] a,
                                     input logic [15:0] b, input logic cin);
    mres_t r;
    int ua, ub, sa, sb, sr, k, ci;
    int unsigned p;
    logic signed [15:0] t;
    ua = int'(a); ub = int'(b); sa = int'($signed(a)); sb = int'($signed(b));
    k = int'(b[3:0]);
    ci = 0;
    r.res = '0; r.wr = 1'b1; r.c = 1'b0; r.v = 1'b0; r.lat = 0; r.legal = 1'b1;
    case (op)
      OP_ADD, OP_ADC, OP_INC: begin
        if (op == OP_INC) begin ub = 1; sb = 1; end
        if (op == OP_ADC) ci = int'(cin);
        r.res = 16'(ua + ub + ci);
        r.c   = (ua + ub + ci) > 65535;
        sr    = sa + sb + ci;
        r.v   = (sr > 32767) || (sr < -32768);
      end
      OP_SUB, OP_SBB, OP_DEC, OP_CMP: begin
        if (op == OP_DEC) begin ub = 1; sb = 1; end
        if (op == OP_SBB) ci = int'(cin);
        r.res = 16'(ua - ub - ci);
        r.c   = ua < (ub + ci);
        sr    = sa - sb - ci;
        r.v   = (sr > 32767) || (sr < -32768);
        r.wr  = (op != OP_CMP);
      end
      OP_AND: r.res = a & b;
      OP_OR:  r.res = a | b;
      OP_XOR: r.res = a ^ b;
      OP_NOT: r.res = ~a;
      OP_SHL, OP_SHR, OP_SAR: begin
        if (k == 0) r.res = a;
        else begin
          r.lat = k;
          if (op == OP_SHL) begin r.res = 16'(ua << k); r.c = a[16-k]; end
          else if (op == OP_SHR) begin r.res = a >> k; r.c = a[k-1]; end
          else begin t = $signed(a) >>> k; r.res = t; r.c = a[k-1]; end
        end
      end
      OP_MUL: begin
        p = ua * ub;
        r.res = p[15:0]; r.c = (p[31:16] != 0); r.v = r.c; r.lat = W;
      end
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

  logic [15:0] m_out = '0;
  logic        m_z = 0, m_s = 0, m_c = 0, m_v = 0, m_done = 0, m_ill = 0;
  int          m_cnt = 0;
  mres_t       pend;

  task automatic m_apply(input mres_t r);
    if (r.wr) m_out = r.res;
    m_z = (r.res == 16'h0); m_s = r.res[15]; m_c = r.c; m_v = r.v;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_out = '0; m_z = 0; m_s = 0; m_c = 0; m_v = 0; m_done = 0; m_ill = 0; m_cnt = 0;
    end else begin
      m_done = 0; m_ill = 0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin m_apply(pend); m_done = 1; end
      end else if (start) begin
        pend = model_op(opcode, in_a, in_b, m_c);
        if (!pend.legal) m_ill = 1;
        else if (pend.lat == 0) begin m_apply(pend); m_done = 1; end
        else m_cnt = pend.lat;
      end
    end
  end

  // Cycle-by-cycle compare of every output against the model.
  always @(posedge clk) begin
    #1;
    check("cycle", {9'b0, out, zf, sf, cf, vf, busy, done, illegal},
          {9'b0, m_out, m_z, m_s, m_c, m_v, (m_cnt != 0), m_done, m_ill});
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    start = 1'b1; opcode = op; in_a = a; in_b = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Edges after the accept edge until done is seen high.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("done_seen", {31'b0, done}, 32'd1);
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [15:0] a, b, o;
    logic [3:0]  f;   // {Z,S,C,V}
    int          lat;
  } vec_t;

  vec_t vt[16];

  initial begin
    vt[0]  = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 0};
    vt[1]  = '{OP_ADC, 16'h0001, 16'h0001, 16'h0003, 4'b0000, 0};
    vt[2]  = '{OP_INC, 16'h7FFF, 16'h0000, 16'h8000, 4'b0101, 0};
    vt[3]  = '{OP_DEC, 16'h8000, 16'h0000, 16'h7FFF, 4'b0001, 0};
    vt[4]  = '{OP_DEC, 16'h0000, 16'h0000, 16'hFFFF, 4'b0110, 0};
    vt[5]  = '{OP_CMP, 16'h0005, 16'h0005, 16'hFFFF, 4'b1000, 0};
    vt[6]  = '{OP_AND, 16'hF0F0, 16'hFF00, 16'hF000, 4'b0100, 0};
    vt[7]  = '{OP_OR,  16'h00F0, 16'h0F00, 16'h0FF0, 4'b0000, 0};
    vt[8]  = '{OP_XOR, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b1000, 0};
    vt[9]  = '{OP_NOT, 16'h00FF, 16'h0000, 16'hFF00, 4'b0100, 0};
    vt[10] = '{OP_SHR, 16'h0003, 16'h0001, 16'h0001, 4'b0010, 1};
    vt[11] = '{OP_SHL, 16'h8001, 16'h0001, 16'h0002, 4'b0010, 1};
    vt[12] = '{OP_SHR, 16'h8000, 16'h000F, 16'h0001, 4'b0000, 15};
    vt[13] = '{OP_SAR, 16'h8000, 16'h000F, 16'hFFFF, 4'b0100, 15};
    vt[14] = '{OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001, 0};
    vt[15] = '{OP_SUB, 16'h0000, 16'h0000, 16'h0000, 4'b1000, 0};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    repeat (2) @(posedge clk);
    #1 check("reset_state", {9'b0, out, zf, sf, cf, vf, busy, done, illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // signed overflow on ADD
    issue(OP_ADD, 16'h7FFF, 16'h0001);
    wait_done(lat);
    check("add_lat", lat, 0);
    check("add_out", out, 16'h8000);
    check("add_flags", {zf, sf, cf, vf}, 4'b0101);

    // borrow out of SUB consumed by SBB
    issue(OP_SUB, 16'h0003, 16'h0005);
    wait_done(lat);
    check("sub_out", out, 16'hFFFE);
    check("sub_flags", {zf, sf, cf, vf}, 4'b0110);
    issue(OP_SBB, 16'h0010, 16'h0000);
    wait_done(lat);
    check("sbb_out", out, 16'h000F);
    check("sbb_flags", {zf, sf, cf, vf}, 4'b0000);

    // arithmetic shift right by 3, then by 0
    issue(OP_SAR, 16'h8004, 16'h0003);
    check("sar_busy", {31'b0, busy}, 32'd1);
    wait_done(lat);
    check("sar_lat", lat, 3);
    check("sar_out", out, 16'hF000);
    check("sar_flags", {zf, sf, cf, vf}, 4'b0110);
    issue(OP_SAR, 16'h8004, 16'h0000);
    wait_done(lat);
    check("sar0_lat", lat, 0);
    check("sar0_out", out, 16'h8004);

    // multiply with high-half overflow, then a small product
    issue(OP_MUL, 16'h0100, 16'h0100);
    wait_done(lat);
    check("mul_lat", lat, 16);
    check("mul_out", out, 16'h0000);
    check("mul_flags", {zf, sf, cf, vf}, 4'b1011);
    issue(OP_MUL, 16'h0003, 16'h0005);
    wait_done(lat);
    check("mul2_out", out, 16'h000F);
    check("mul2_flags", {zf, sf, cf, vf}, 4'b0000);

    // directed table, each op issued back-to-back on the previous done
    foreach (vt[i]) begin
      issue(vt[i].op, vt[i].a, vt[i].b);
      wait_done(lat);
      check($sformatf("vec%0d_lat", i), lat, vt[i].lat);
      check($sformatf("vec%0d_out", i), out, vt[i].o);
      check($sformatf("vec%0d_flags", i), {zf, sf, cf, vf}, vt[i].f);
    end

    // start held during MUL busy is ignored
    issue(OP_MUL, 16'h0003, 16'h0005);
    opcode = OP_ADD; in_a = 16'h0001; in_b = 16'h0001; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check("busy_start_lat", lat, 13);
    check("busy_start_out", out, 16'h000F);
    @(negedge clk);
    check("busy_start_idle", {30'b0, busy, done}, 32'd0);

    // illegal opcode while idle
    issue(5'h1F, 16'h1234, 16'h5678);
    check("illegal_pulse", {30'b0, illegal, done}, 32'd2);
    check("illegal_hold", {12'b0, out, zf, sf, cf, vf}, {12'b0, 16'h000F, 4'b0000});
    @(negedge clk);
    check("illegal_once", {30'b0, illegal, done}, 32'd0);

    // reset in the middle of a shift
    issue(OP_SHL, 16'h0001, 16'h0005);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1 check("reset_mid", {9'b0, out, zf, sf, cf, vf, busy, done, illegal}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(OP_ADD, 16'h0000, 16'h0000);
    wait_done(lat);
    check("post_reset_lat", lat, 0);
    check("post_reset_out", out, 16'h0000);
    check("post_reset_flags", {zf, sf, cf, vf}, 4'b1000);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
